// File: rtl/sample_feeder.sv
// ============================================================================
// Module   : sample_feeder
// Purpose  : Synchronizes and debounces the store/next buttons and the switch
//            bank, emitting single-cycle store and advance strobes.
//            Optional auto-repeat of next_sample: define FEEDER_AUTO_REPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sample_feeder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw_in,
    input  logic       btn_store,
    input  logic       btn_next,
    output logic [7:0] sample_data,
    output logic       sample_valid,
    output logic       next_sample
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("sample_feeder: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    logic [7:0] sw_s1_q, sw_s2_q;
    logic [1:0] btn_s1_q, btn_s2_q;   // bit 0 = store, bit 1 = next
    logic [1:0] rise_w;
    logic       next_fire_w;
    logic [7:0] sample_data_q;
    logic       sample_valid_q, next_sample_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
            btn_s1_q <= '0;
            btn_s2_q <= '0;
        end else begin
            sw_s1_q  <= sw_in;
            sw_s2_q  <= sw_s1_q;
            btn_s1_q <= {btn_next, btn_store};
            btn_s2_q <= btn_s1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_deb
            logic [CW-1:0] cnt_q, cnt_d;
            logic          stable_q, stable_d;
            logic          flip_w;

            assign flip_w = (btn_s2_q[gi] != stable_q) && (cnt_q == CNT_MAX);

            // Any cycle where the synchronized level matches stable restarts the count.
            always_comb begin
                stable_d = stable_q;
                cnt_d    = '0;
                if (btn_s2_q[gi] != stable_q) begin
                    if (flip_w) stable_d = btn_s2_q[gi];
                    else        cnt_d    = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else begin
                    cnt_q    <= cnt_d;
                    stable_q <= stable_d;
                end
            end

            assign rise_w[gi] = flip_w & btn_s2_q[gi];
        end
    endgenerate

`ifdef FEEDER_AUTO_REPEAT_EN
    localparam int            RW      = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_fire_w;
    logic          next_fall_w;

    assign next_fall_w = g_deb[1].flip_w & ~btn_s2_q[1];

    // Counter is held at zero while released, on the rising flip and on the falling flip.
    always_comb begin
        rpt_d      = rpt_q;
        rpt_fire_w = 1'b0;
        if (!g_deb[1].stable_q || next_fall_w) begin
            rpt_d = '0;
        end else if (rpt_q == RPT_MAX) begin
            rpt_fire_w = 1'b1;
            rpt_d      = '0;
        end else begin
            rpt_d = rpt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rpt_q <= '0;
        else       rpt_q <= rpt_d;
    end

    assign next_fire_w = rise_w[1] | rpt_fire_w;
`else
    assign next_fire_w = rise_w[1];
`endif

    // Store has priority: a coincident advance strobe is dropped, not deferred.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            next_sample_q  <= 1'b0;
        end else begin
            sample_valid_q <= rise_w[0];
            next_sample_q  <= next_fire_w & ~rise_w[0];
            if (rise_w[0]) sample_data_q <= sw_s2_q;
        end
    end

    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign next_sample  = next_sample_q;

endmodule

`default_nettype wire

// File: tb/tb_sample_feeder.sv
// ============================================================================
// Module   : tb_sample_feeder
// Purpose  : Directed self-checking bench for sample_feeder with a window-based
//            reference model compared every cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sample_feeder;

    localparam int DC = 4;
    localparam int RC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] sw_in = 8'h00;
    logic       btn_store = 1'b0;
    logic       btn_next = 1'b0;
    logic [7:0] sample_data;
    logic       sample_valid;
    logic       next_sample;

    int n_pass  = 0;
    int n_total = 0;

    sample_feeder #(
        .DEBOUNCE_CYCLES (DC),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw_in        (sw_in),
        .btn_store    (btn_store),
        .btn_next     (btn_next),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .next_sample  (next_sample)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a level is accepted once the last DC synchronized
    // samples seen since the previous acceptance all disagree with it.
    logic       s_rst, s_st, s_nx;
    logic [7:0] s_sw;
    logic       m1_st, m2_st, m1_nx, m2_nx;
    logic [7:0] m1_sw, m2_sw;
    logic       in_st, in_nx;
    logic [7:0] in_sw;
    bit         q_st[$];
    bit         q_nx[$];
    logic       stab_st, stab_nx, rise_st, rise_nx, rep, diff;
    int         since;
    logic       e_valid, e_next;
    logic [7:0] e_data;

    initial begin : model
        m1_st = 0; m2_st = 0; m1_nx = 0; m2_nx = 0; m1_sw = 0; m2_sw = 0;
        stab_st = 0; stab_nx = 0; since = 0;
        e_valid = 0; e_next = 0; e_data = 0;
        forever begin
            @(posedge clk);
            s_rst = reset; s_st = btn_store; s_nx = btn_next; s_sw = sw_in;
            @(negedge clk);
            if (reset) begin
                m1_st = 0; m2_st = 0; m1_nx = 0; m2_nx = 0; m1_sw = 0; m2_sw = 0;
                q_st.delete(); q_nx.delete();
                stab_st = 0; stab_nx = 0; since = 0;
                e_valid = 0; e_next = 0; e_data = 0;
            end else if (!s_rst) begin
                in_st = m2_st; in_nx = m2_nx; in_sw = m2_sw;
                m2_st = m1_st; m2_nx = m1_nx; m2_sw = m1_sw;
                m1_st = s_st;  m1_nx = s_nx;  m1_sw = s_sw;
                rise_st = 0; rise_nx = 0; rep = 0;

                q_st.push_back(in_st);
                if (q_st.size() > DC) void'(q_st.pop_front());
                diff = 1;
                foreach (q_st[k]) if (q_st[k] == stab_st) diff = 0;
                if (q_st.size() == DC && diff) begin
                    stab_st = ~stab_st; rise_st = stab_st; q_st.delete();
                end

                q_nx.push_back(in_nx);
                if (q_nx.size() > DC) void'(q_nx.pop_front());
                diff = 1;
                foreach (q_nx[k]) if (q_nx[k] == stab_nx) diff = 0;
                if (q_nx.size() == DC && diff) begin
                    stab_nx = ~stab_nx; rise_nx = stab_nx; q_nx.delete();
                end

`ifdef FEEDER_AUTO_REPEAT_EN
                if (rise_nx)      since = 0;
                else if (stab_nx) since++;
                rep = stab_nx && !rise_nx && since > 0 && (since % RC) == 0;
`endif
                e_valid = rise_st;
                e_next  = (rise_nx || rep) && !rise_st;
                if (rise_st) e_data = in_sw;
            end
            chk("cycle", {22'd0, sample_valid, next_sample, sample_data},
                         {22'd0, e_valid, e_next, e_data});
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic st, input logic nx, input int hold, input int total,
                         output int nv, output int nn, output int fv, output int fn,
                         output int ln);
        nv = 0; nn = 0; fv = -1; fn = -1; ln = -1;
        @(negedge clk);
        btn_store = st; btn_next = nx;
        for (int i = 0; i < total; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sample_valid) begin nv++; if (fv < 0) fv = i; end
            if (next_sample) begin nn++; if (fn < 0) fn = i; ln = i; end
            if (i == hold - 1) begin btn_store = 1'b0; btn_next = 1'b0; end
        end
    endtask

    initial begin : stim
        int nv, nn, fv, fn, ln, early;

        // Reset held with inputs toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_outputs", {22'd0, sample_valid, next_sample, sample_data}, 32'd0);
            btn_store = ~btn_store;
            btn_next  = ~btn_next;
            sw_in     = 8'($urandom);
        end
        @(negedge clk);
        btn_store = 0; btn_next = 0; sw_in = 8'h00;
        #2 reset = 1'b0;
        idle(8);

        // Clean store press
        sw_in = 8'hA5;
        idle(4);
        press(1'b1, 1'b0, 20, 30, nv, nn, fv, fn, ln);
        chk("store_count", nv, 1);
        chk("store_edge", fv, 5);
        chk("store_no_next", nn, 0);
        chk("store_data", {24'd0, sample_data}, 32'hA5);
        sw_in = 8'h3C;
        idle(10);
        chk("data_hold", {24'd0, sample_data}, 32'hA5);

        // Bouncing store button
        nv = 0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (sample_valid) nv++;
            btn_store = (i < 16) && ((i % 4) < 2);
        end
        chk("bounce_no_valid", nv, 0);
        chk("bounce_data", {24'd0, sample_data}, 32'hA5);

        // Simultaneous store and next
        sw_in = 8'h5A;
        idle(4);
        press(1'b1, 1'b1, 10, 20, nv, nn, fv, fn, ln);
        chk("both_valid_count", nv, 1);
        chk("both_valid_edge", fv, 5);
        chk("both_next_dropped", nn, 0);
        chk("both_data", {24'd0, sample_data}, 32'h5A);

        // Long next press
        press(1'b0, 1'b1, 40, 50, nv, nn, fv, fn, ln);
        chk("next_first", fn, 5);
`ifdef FEEDER_AUTO_REPEAT_EN
        chk("next_count", nn, 5);
        chk("next_last", ln, 37);
`else
        chk("next_count", nn, 1);
        chk("next_last", ln, 5);
`endif
        chk("next_no_valid", nv, 0);

        // Reset mid-press: button still held afterwards is a new press
        sw_in = 8'hC3;
        early = 0; nv = 0; fv = -1;
        @(negedge clk);
        btn_store = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            if (i == 3) #2 reset = 1'b1;
            if (i == 6) #2 reset = 1'b0;
            @(negedge clk);
            if (sample_valid) early++;
        end
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sample_valid) begin nv++; if (fv < 0) fv = i; end
            if (i == 9) btn_store = 1'b0;
        end
        chk("reset_no_early", early, 0);
        chk("reset_valid_count", nv, 1);
        chk("reset_valid_edge", fv, 5);
        chk("reset_data", {24'd0, sample_data}, 32'hC3);

        idle(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sample_feeder.md
# sample_feeder

Front-end producer for the sample stash. Synchronizes and debounces two raw board push-buttons and the 8-bit switch bank, and converts each clean press into single-cycle strobes. A store press yields a `sample_valid` pulse carrying the captured switch byte in `sample_data`; a next press yields a `next_sample` pulse. These outputs connect directly to the stash's store and advance inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required to accept a button level change; legal range ≥ 2.
- `REPEAT_CYCLES`, default 64: period in cycles of auto-repeat `next_sample` pulses; legal range ≥ 2. Used only with the configuration macro.
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `sw_in` input 8: raw switch bank, asynchronous to `clk`.
- `btn_store` input 1: raw store button, asynchronous, active-high.
- `btn_next` input 1: raw next button, asynchronous, active-high.
- `sample_data` output 8: last captured switch byte; holds between captures.
- `sample_valid` output 1: one-cycle strobe; `sample_data` is new in that cycle.
- `next_sample` output 1: one-cycle advance strobe.

## Operation
- Synchronization:
  - `btn_store`, `btn_next` and every `sw_in` bit pass through a two-flop synchronizer.
  - Only synchronized values are used downstream.
- Debouncer per button (independent instances):
  - Holds `stable` (reset 0) and a counter `cnt` of width $clog2(DEBOUNCE_CYCLES).
  - Each edge when sync == stable: cnt <= 0.
  - Each edge when sync != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Each edge when sync != stable and cnt == DEBOUNCE_CYCLES-1: stable <= sync, cnt <= 0.
- Store path:
  - On the edge where store `stable` flips 0→1, `sample_valid` <= 1 and `sample_data` <= synchronized `sw_in`.
  - `sample_valid` returns to 0 on the following edge.
  - A 1→0 flip produces nothing.
- Next path:
  - On the edge where next `stable` flips 0→1, `next_sample` <= 1 for one cycle.
- Simultaneous store and next rising flips on the same edge: store wins. `sample_valid` pulses and the `next_sample` pulse is dropped, not deferred.
- Strobes never exceed one cycle. Two strobes of the same kind are separated by at least 2·DEBOUNCE_CYCLES cycles.
- Reset:
  - All outputs, synchronizers, `stable`, counters and the repeat counter go to 0 asynchronously.
  - A button still held when reset deasserts counts as a new press and strobes again after the normal latency.

## Timing
- Definition: E0 is the first edge at which synchronizer flop 1 captures a 1. Sync is high after E1.
- Strobe is asserted at edge E(DEBOUNCE_CYCLES+1) and deasserted at E(DEBOUNCE_CYCLES+2). Latency is exactly DEBOUNCE_CYCLES+1 edges after E0.
- `sample_data` takes `sw_in` as synchronized at E(DEBOUNCE_CYCLES+1). `sw_in` must be steady for at least 2 cycles before that edge.
- Any sync glitch back to the stable value restarts the count from 0. Pulses shorter than DEBOUNCE_CYCLES cycles are rejected.
- Outputs are registered and have no combinational paths from inputs.

## Configuration
- `FEEDER_AUTO_REPEAT_EN` defined:
  - While next `stable` stays 1, a repeat counter (cleared on the rising flip) counts edges.
  - When the counter reaches REPEAT_CYCLES-1, `next_sample` pulses for one cycle and the counter clears. Result: one pulse every REPEAT_CYCLES cycles after the first.
  - The counter clears and repeats stop on the edge that `stable` falls.
  - A repeat pulse coinciding with a store rising flip is dropped (store priority).
- `FEEDER_AUTO_REPEAT_EN` undefined: exactly one `next_sample` per press. The repeat counter and `REPEAT_CYCLES` are not synthesized.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
- Reset asserted for 3 cycles with buttons and switches toggling → `sample_data`=0x00, `sample_valid`=0, `next_sample`=0 throughout, including the cycle reset rises.
- `sw_in`=0xA5 steady, `btn_store` held 20 cycles → single `sample_valid` at E5; `sample_data`=0xA5 from E5 onward. Then `sw_in`=0x3C with no press → `sample_data` stays 0xA5.
- Bounce: `btn_store` toggles every 2 cycles for 16 cycles, then stays low → no `sample_valid`; `sample_data` unchanged.
- `btn_store` and `btn_next` rise on the same edge, both held 10 cycles → one `sample_valid` at E5 and no `next_sample` at all.
- `btn_next` held 40 cycles → with `FEEDER_AUTO_REPEAT_EN`: pulses at E5, E13, E21, E29, E37 (5 total), none after `stable` falls. Without the macro: only the E5 pulse.
- `btn_store` held; reset asserted asynchronously mid-cycle at E3 and released at E6 → no strobe before E6. Exactly one `sample_valid` at 5 edges after the first post-reset capture edge.
